// File: rtl/disp_scan_ctrl.sv
// Four-digit hex scanner for a shared 7-segment bus: slot timing, blanked decoder enable,
// registered segment pattern and a frame-coherent load/commit handshake.
module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int DIV_W     = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [15:0] VALUE,
    input  logic        LEADZ,
    output logic [1:0]  SEL,
    output logic        EN,
    output logic [6:0]  SEG,
    output logic        ACK
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] CNT_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic [6:0]       seg_q, seg_d;
    logic             ack_q, ack_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;

    logic             slot_end;
    logic             commit;
    logic [6:0]       dig_seg [4];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign dig_seg[gi] = hex7(disp_q[3:0]);
            end else begin : g_upper
                logic lead_zero;
                assign lead_zero   = ~|disp_q[15:4*gi];
                assign dig_seg[gi] = (LEADZ && lead_zero) ? 7'h00 : hex7(disp_q[4*gi +: 4]);
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)            state_d = ST_BLANK;
            default:                           state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        commit    = slot_end && (sel_q == 2'd3) && pending_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        sel_d     = slot_end ? sel_q + 2'd1 : sel_q;
        en_d      = (state_d == ST_SHOW);
        // Segment pattern latches during the first blank cycle so it is settled before EN rises.
        seg_d     = (cnt_q == '0) ? dig_seg[sel_q] : seg_q;
        ack_d     = commit;
        disp_d    = commit ? shadow_q : disp_q;
        shadow_d  = LOAD ? VALUE : shadow_q;
        pending_d = LOAD | (pending_q & ~commit);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
            seg_q     <= 7'h00;
            ack_q     <= 1'b0;
            disp_q    <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            seg_q     <= seg_d;
            ack_q     <= ack_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign SEL = sel_q;
    assign EN  = en_q;
    assign SEG = seg_q;
    assign ACK = ack_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a cycle-time reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_disp_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LOAD;
    logic [15:0] VALUE;
    logic        LEADZ;
    logic [1:0]  SEL;
    logic        EN;
    logic [6:0]  SEG;
    logic        ACK;

    always #5 CLK = ~CLK;

    disp_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .DIV_W    (16)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .LOAD (LOAD),
        .VALUE(VALUE),
        .LEADZ(LEADZ),
        .SEL  (SEL),
        .EN   (EN),
        .SEG  (SEG),
        .ACK  (ACK)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic [6:0] seg;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference state: t = cycles since the last reset edge.
    int          t        = 0;
    logic [15:0] m_disp   = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend   = 1'b0;
    bit          m_ack    = 1'b0;
    logic [6:0]  m_seg    = 7'h0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int dig, input bit lz);
        logic [3:0] n;
        n = v[4*dig +: 4];
        if (lz && dig > 0 && (v >> (4 * dig)) == 16'h0) return 7'h00;
        return hex_tab[n];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, expv);
        end
    endtask

    // One clock cycle: apply inputs, queue the expected outputs for this cycle, advance the model.
    task automatic cycle(input bit rst_n, input bit load, input logic [15:0] value, input bit lz);
        exp_t e;
        RST_N = rst_n;
        LOAD  = load;
        VALUE = value;
        LEADZ = lz;
        e.sel = 2'((t / SCAN_DIV) % 4);
        e.en  = (t % SCAN_DIV) >= BLANK_CYC;
        e.seg = m_seg;
        e.ack = m_ack;
        exp_q.push_back(e);
        if (!rst_n) begin
            $display("reset cycle=%0d", cyc);
            t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_ack = 1'b0; m_seg = 7'h0;
        end else begin
            bit commit;
            commit = ((t % FRAME) == FRAME - 1) && m_pend;
            if (load) $display("load cycle=%0d value=%h leadz=%0d commit_edge=%0d", cyc, value, lz, commit);
            if ((t % SCAN_DIV) == 0) m_seg = ref_seg(m_disp, (t / SCAN_DIV) % 4, lz);
            m_ack = commit;
            if (commit) m_disp = m_shadow;
            if (load) begin
                m_shadow = value;
                m_pend   = 1'b1;
            end else if (commit) begin
                m_pend = 1'b0;
            end
            t++;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input bit lz);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, lz);
    endtask

    task automatic run_to_pos(input int pos, input bit lz);
        while ((t % FRAME) != pos) cycle(1'b1, 1'b0, 16'h0, lz);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sel", 16'(SEL), 16'(mon_e.sel));
            check("en",  16'(EN),  16'(mon_e.en));
            check("seg", 16'(SEG), 16'(mon_e.seg));
            check("ack", 16'(ACK), 16'(mon_e.ack));
            if (ACK === 1'b1) $display("ack cycle=%0d sel=%0d", cyc, SEL);
        end
    end

    initial begin
        bit lz_r;
        RST_N = 1'b0;
        LOAD  = 1'b1;
        VALUE = 16'hFFFF;
        LEADZ = 1'b0;
        @(posedge CLK);
        #1;
        // Reset held with a load strobe that must be discarded
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
        run(40, 1'b0);
        // Load during slot 1, commit at the frame boundary
        run_to_pos(SCAN_DIV + 3, 1'b0);
        cycle(1'b1, 1'b1, 16'h12AF, 1'b0);
        run_to_pos(FRAME - 1, 1'b0);
        run(FRAME + 2, 1'b0);
        // Leading-zero suppression
        cycle(1'b1, 1'b1, 16'h0030, 1'b1);
        run_to_pos(FRAME - 1, 1'b1);
        run(FRAME + 2, 1'b1);
        cycle(1'b1, 1'b1, 16'h0000, 1'b1);
        run_to_pos(FRAME - 1, 1'b1);
        run(FRAME + 2, 1'b1);
        cycle(1'b1, 1'b1, 16'h0030, 1'b0);
        run_to_pos(FRAME - 1, 1'b0);
        run(FRAME + 2, 1'b0);
        // Two loads in a frame, then a load exactly on the commit edge
        run_to_pos(4, 1'b0);
        cycle(1'b1, 1'b1, 16'h1111, 1'b0);
        run_to_pos(20, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 1'b0);
        run_to_pos(FRAME - 1, 1'b0);
        cycle(1'b1, 1'b1, 16'h3333, 1'b0);
        run(2 * FRAME, 1'b0);
        // Pending load discarded by a reset in mid-SHOW
        run_to_pos(2, 1'b0);
        cycle(1'b1, 1'b1, 16'hABCD, 1'b0);
        run_to_pos(12, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        run(2 * FRAME + 4, 1'b0);
        // Randomized traffic
        lz_r = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (($urandom % 50) == 0) lz_r = ~lz_r;
            cycle(($urandom % 300) != 0, ($urandom % 12) == 0, 16'($urandom), lz_r);
        end
        run(4, lz_r);
        @(negedge CLK);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
